membrane_update_ctrl: RTL
=========================

// Module: membrane_update_ctrl
// PURPOSE
//  Read-modify-write sequencer for the neuron membrane-potential true dual-port BRAM in the SNN core.
//  Takes weighted spike events, reads the potential on BRAM port A and adds the weight with saturation.
//  Compares the sum with the threshold and writes the result back on port B; emits an output spike on threshold crossing.
//  Sustains 1 event/cycle, forwards back-to-back same-neuron hazards, and provides a full-memory clear sweep.
// PARAMETERS
//  DATA_WIDTH  16  signed membrane potential / weight width (two's complement)
//  ADDR_WIDTH  10  neuron address width; memory depth 2**ADDR_WIDTH
//  V_RESET     0   potential written after a spike and by the clear sweep
// PORTS
//  clk          in   1           single clock; both BRAM ports are driven from it
//  rst_n        in   1           asynchronous active-low reset
//  ev_valid     in   1           event valid
//  ev_ready     out  1           event accepted when ev_valid && ev_ready
//  ev_addr      in   ADDR_WIDTH  target neuron
//  ev_weight    in   DATA_WIDTH  signed weight
//  threshold    in   DATA_WIDTH  signed firing threshold; must be stable while busy
//  clear_start  in   1           request clear sweep (pulse)
//  busy         out  1           high while the pipeline is non-empty or the sweep is running
//  ram_ena      out  1           BRAM port A enable (read only; port A write enable tied 0)
//  ram_addra    out  ADDR_WIDTH  BRAM port A address
//  ram_doa      in   DATA_WIDTH  BRAM port A registered read data, 1-cycle latency
//  ram_enb      out  1           BRAM port B enable
//  ram_web      out  1           BRAM port B write enable
//  ram_addrb    out  ADDR_WIDTH  BRAM port B address
//  ram_dib      out  DATA_WIDTH  BRAM port B write data
//  spike_valid  out  1           1-cycle pulse: neuron spike_addr fired (no backpressure)
//  spike_addr   out  ADDR_WIDTH  firing neuron
//  spike_count  out  16          saturating count of spikes since reset or last clear
// BEHAVIOUR
//  Reset: FSM=IDLE; ev_ready, busy, ram_ena, ram_enb, ram_web, spike_valid all 0; addresses, data, spike_count 0.
//  FSM states: IDLE -> RUN on the first accepted event; RUN -> IDLE once the pipeline is empty and no event is accepted.
//  FSM, IDLE/RUN -> CLEAR: on clear_start while the pipeline is empty. CLEAR -> IDLE after the last address is written.
//  clear_start arriving while the pipeline is non-empty is held pending until the pipeline drains, then honoured.
//  ev_ready = 1 in IDLE/RUN with no clear pending; ev_ready = 0 in CLEAR and while a clear is pending.
//  Stage S0 (accept cycle t): ram_ena=1, ram_addra=ev_addr; addr and weight are registered into S1.
//  Stage S1 (cycle t+1): ram_doa is valid; old = fwd ? last_written : ram_doa.
//  S1 sum = old + weight, computed at DATA_WIDTH+1 bits and clamped to [-2^(W-1), 2^(W-1)-1].
//  S1 on fire (sum >= threshold, signed compare): ram_enb=ram_web=1, ram_addrb=addr, ram_dib=V_RESET.
//  S1 fire also asserts spike_valid/spike_addr combinationally in the same cycle and increments spike_count (sticks at 0xFFFF).
//  S1 without fire: ram_enb=ram_web=1, ram_addrb=addr, ram_dib=sum.
//  Latency: accept at t -> BRAM write and spike at t+1; the write is visible to a port-A read at t+2.
//  Hazard: if the S0 address equals the S1 address in the same cycle, fwd is set for the next cycle.
//   Under fwd, S1 uses the value written in the prior cycle rather than ram_doa. Only a 1-deep hazard exists.
//  Events to different addresses never stall. No idle cycles are inserted for same-address back-to-back events.
//  CLEAR: counter runs 0..2**ADDR_WIDTH-1, one write per cycle (ram_enb=ram_web=1, ram_dib=V_RESET); ram_ena=0.
//   spike_count is zeroed on CLEAR entry. The clear lasts 2**ADDR_WIDTH cycles; the counter does not wrap.
//  threshold changes while busy=1 are unsupported. The pipeline never drops an accepted event.
//  Asynchronous reset mid-operation aborts any in-flight write or sweep and returns to reset values; BRAM contents are left undefined.
// TESTING
//  1 Clear, then event (n=5,w=+10), thr=100 -> t+1: write addr5=10, no spike; readback 10.
//  2 Ten back-to-back events n=7,w=+10, thr=100 -> writes 10..90, then event 10 writes 0 and spike_valid=1 with spike_addr=7.
//    Checks: one spike total, no stall, forwarding exercised every cycle.
//  3 Alternating n=3/n=4, w=+1, 6 events -> final mem[3]=3, mem[4]=3, fwd never asserted.
//  4 mem=0x7FF0, w=+0x7F, thr=0x7FFF -> sum clamps to 0x7FFF, fires. mem=-32760, w=-100 -> clamps to 0x8000, no fire.
//  5 clear_start with 2 events in flight -> both complete, then 1024 writes of 0.
//    During the sweep ev_ready=0 and busy=1; spike_count=0 afterwards.
//  6 Assert rst_n=0 during CLEAR and during RUN -> all outputs return to reset values the same cycle; the next event is accepted normally.

Source files
------------

// File: rtl/membrane_update_ctrl.sv
// Membrane-potential read-modify-write sequencer: one event per cycle, port A read,
// saturating add and threshold test in S1, port B write-back, plus a full-memory clear sweep.
module membrane_update_ctrl #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] V_RESET    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic [ADDR_WIDTH-1:0] ev_addr,
  input  logic [DATA_WIDTH-1:0] ev_weight,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic                  clear_start,
  output logic                  busy,
  output logic                  ram_ena,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  input  logic [DATA_WIDTH-1:0] ram_doa,
  output logic                  ram_enb,
  output logic                  ram_web,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic [DATA_WIDTH-1:0] ram_dib,
  output logic                  spike_valid,
  output logic [ADDR_WIDTH-1:0] spike_addr,
  output logic [15:0]           spike_count
);

  typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

  localparam logic [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                  state;
  logic                    clear_pending;
  logic                    s1_valid;
  logic                    fwd;
  logic [ADDR_WIDTH-1:0]   s1_addr;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   s1_weight;
  logic [DATA_WIDTH-1:0]   last_written;

  logic                    accept;
  logic                    clear_req;
  logic                    s1_fire;
  logic [DATA_WIDTH-1:0]   old_val;
  logic [DATA_WIDTH:0]     sum_ext;
  logic [DATA_WIDTH-1:0]   sum_sat;
  logic [DATA_WIDTH-1:0]   wr_data;

  assign accept    = ev_valid && ev_ready;
  assign clear_req = clear_start || clear_pending;

  // The BRAM cannot return a value written in the previous cycle, so take it from the write-back register.
  assign old_val = fwd ? last_written : ram_doa;
  assign sum_ext = {old_val[DATA_WIDTH-1], old_val} + {s1_weight[DATA_WIDTH-1], s1_weight};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sum_sat = sum_ext[DATA_WIDTH-1:0];
    if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1])
      sum_sat = sum_ext[DATA_WIDTH] ? MIN_V : MAX_V;
  end

  assign s1_fire = s1_valid && ($signed(sum_sat) >= $signed(threshold));
  assign wr_data = s1_fire ? V_RESET : sum_sat;

  assign busy        = s1_valid || clear_pending || (state == CLEAR);
  assign ram_ena     = accept;
  assign ram_addra   = accept ? ev_addr : '0;
  assign spike_valid = s1_fire;
  assign spike_addr  = s1_fire ? s1_addr : '0;

  always_comb begin
    ram_enb   = 1'b0;
    ram_web   = 1'b0;
    ram_addrb = '0;
    ram_dib   = '0;
    if (state == CLEAR) begin
      ram_enb   = 1'b1;
      ram_web   = 1'b1;
      ram_addrb = clr_cnt;
      ram_dib   = V_RESET;
    end else if (s1_valid) begin
      ram_enb   = 1'b1;
      ram_web   = 1'b1;
      ram_addrb = s1_addr;
      ram_dib   = wr_data;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ev_ready      <= 1'b0;
      clear_pending <= 1'b0;
      clr_cnt       <= '0;
      s1_valid      <= 1'b0;
      s1_addr       <= '0;
      s1_weight     <= '0;
      fwd           <= 1'b0;
      last_written  <= '0;
      spike_count   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr   <= ev_addr;
        s1_weight <= ev_weight;
      end
      fwd <= accept && s1_valid && (ev_addr == s1_addr);
      if (s1_valid) last_written <= wr_data;
      if (s1_fire && (spike_count != 16'hFFFF)) spike_count <= spike_count + 16'd1;

      case (state)
        IDLE, RUN: begin
          if (clear_req && !s1_valid && !accept) begin
            state         <= CLEAR;
            clear_pending <= 1'b0;
            clr_cnt       <= '0;
            spike_count   <= '0;
            ev_ready      <= 1'b0;
          end else begin
            // A clear seen while events are in flight waits here until the pipeline drains.
            clear_pending <= clear_req;
            ev_ready      <= !clear_req;
            if (accept)         state <= RUN;
            else if (!s1_valid) state <= IDLE;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            ev_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
